// File: rtl/fmap_arbiter_if.sv
// Client-side bus between the conv/pool stages and the feature-map arbiter.
// Each client owns one read channel and one write channel, both using req/gnt.
interface fmap_arbiter_if #(
  parameter int BITS_PER_COORDINATE = 8,
  parameter int OUT_CHANNELS        = 4,
  parameter int BITS_PER_NEURON     = 8
);
  localparam int DATA_W = OUT_CHANNELS * BITS_PER_NEURON;

  logic                           conv_rd_req;
  logic [BITS_PER_COORDINATE-1:0] conv_rd_x;
  logic [BITS_PER_COORDINATE-1:0] conv_rd_y;
  logic                           conv_rd_gnt;
  logic                           conv_rd_valid;
  logic [DATA_W-1:0]              conv_rd_data;
  logic                           conv_wr_req;
  logic [BITS_PER_COORDINATE-1:0] conv_wr_x;
  logic [BITS_PER_COORDINATE-1:0] conv_wr_y;
  logic [DATA_W-1:0]              conv_wr_data;
  logic                           conv_wr_gnt;

  logic                           pool_rd_req;
  logic [BITS_PER_COORDINATE-1:0] pool_rd_x;
  logic [BITS_PER_COORDINATE-1:0] pool_rd_y;
  logic                           pool_rd_gnt;
  logic                           pool_rd_valid;
  logic [DATA_W-1:0]              pool_rd_data;
  logic                           pool_wr_req;
  logic [BITS_PER_COORDINATE-1:0] pool_wr_x;
  logic [BITS_PER_COORDINATE-1:0] pool_wr_y;
  logic [DATA_W-1:0]              pool_wr_data;
  logic                           pool_wr_gnt;

  modport master (
    output conv_rd_req, conv_rd_x, conv_rd_y, conv_wr_req, conv_wr_x, conv_wr_y, conv_wr_data,
    output pool_rd_req, pool_rd_x, pool_rd_y, pool_wr_req, pool_wr_x, pool_wr_y, pool_wr_data,
    input  conv_rd_gnt, conv_rd_valid, conv_rd_data, conv_wr_gnt,
    input  pool_rd_gnt, pool_rd_valid, pool_rd_data, pool_wr_gnt
  );

  modport slave (
    input  conv_rd_req, conv_rd_x, conv_rd_y, conv_wr_req, conv_wr_x, conv_wr_y, conv_wr_data,
    input  pool_rd_req, pool_rd_x, pool_rd_y, pool_wr_req, pool_wr_x, pool_wr_y, pool_wr_data,
    output conv_rd_gnt, conv_rd_valid, conv_rd_data, conv_wr_gnt,
    output pool_rd_gnt, pool_rd_valid, pool_rd_data, pool_wr_gnt
  );
endinterface

// File: rtl/fmap_arbiter.sv
// Feature-map BRAM arbiter: independent round-robin read and write paths for the
// conv and pool clients, coordinate-to-address mapping and write-to-read forwarding.
module fmap_arbiter #(
  parameter int BITS_PER_COORDINATE = 8,
  parameter int OUT_CHANNELS        = 4,
  parameter int BITS_PER_NEURON     = 8,
  parameter int FM_WIDTH            = 32,
  parameter int FM_HEIGHT           = 32,
  localparam int DATA_W = OUT_CHANNELS * BITS_PER_NEURON,
  localparam int ADDR_W = $clog2(FM_WIDTH * FM_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  fmap_arbiter_if.slave     arb,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              oob_err
);
  localparam int CW = BITS_PER_COORDINATE + 1;

  // One extra bit so a bound equal to 2**BITS_PER_COORDINATE still compares correctly.
  function automatic logic in_range(input logic [BITS_PER_COORDINATE-1:0] x,
                                    input logic [BITS_PER_COORDINATE-1:0] y);
    return ({1'b0, x} < CW'(FM_WIDTH)) && ({1'b0, y} < CW'(FM_HEIGHT));
  endfunction

  function automatic logic [ADDR_W-1:0] map_addr(input logic [BITS_PER_COORDINATE-1:0] x,
                                                 input logic [BITS_PER_COORDINATE-1:0] y);
    return ADDR_W'(y) * ADDR_W'(FM_WIDTH) + ADDR_W'(x);
  endfunction

  logic rd_ptr_q, rd_ptr_d;
  logic wr_ptr_q, wr_ptr_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_owner_q, rd_owner_d;
  logic rd_oob_q, rd_oob_d;
  logic fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic oob_err_q, oob_err_d;

  logic rd_gnt_conv, rd_gnt_pool, rd_any;
  logic wr_gnt_conv, wr_gnt_pool, wr_any;
  logic [BITS_PER_COORDINATE-1:0] rd_x, rd_y, wr_x, wr_y;
  logic [DATA_W-1:0] wr_data_sel;
  logic rd_ok, wr_ok;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] ret_data;

  // Pointer value 0 favours conv, 1 favours pool; grants are masked during reset.
  always_comb begin
    rd_gnt_conv = !rst && arb.conv_rd_req && (!arb.pool_rd_req || !rd_ptr_q);
    rd_gnt_pool = !rst && arb.pool_rd_req && (!arb.conv_rd_req ||  rd_ptr_q);
    wr_gnt_conv = !rst && arb.conv_wr_req && (!arb.pool_wr_req || !wr_ptr_q);
    wr_gnt_pool = !rst && arb.pool_wr_req && (!arb.conv_wr_req ||  wr_ptr_q);
    rd_any      = rd_gnt_conv || rd_gnt_pool;
    wr_any      = wr_gnt_conv || wr_gnt_pool;
  end

  always_comb begin
    rd_x        = rd_gnt_pool ? arb.pool_rd_x : arb.conv_rd_x;
    rd_y        = rd_gnt_pool ? arb.pool_rd_y : arb.conv_rd_y;
    wr_x        = wr_gnt_pool ? arb.pool_wr_x : arb.conv_wr_x;
    wr_y        = wr_gnt_pool ? arb.pool_wr_y : arb.conv_wr_y;
    wr_data_sel = wr_gnt_pool ? arb.pool_wr_data : arb.conv_wr_data;
    rd_ok       = rd_any && in_range(rd_x, rd_y);
    wr_ok       = wr_any && in_range(wr_x, wr_y);
    rd_addr     = map_addr(rd_x, rd_y);
    wr_addr     = map_addr(wr_x, wr_y);
  end

  // Out-of-range accesses are granted but never reach the BRAM.
  always_comb begin
    mem_rd_en   = rd_ok;
    mem_rd_addr = rd_ok ? rd_addr : '0;
    mem_wr_en   = wr_ok;
    mem_wr_addr = wr_ok ? wr_addr : '0;
    mem_wr_data = wr_ok ? wr_data_sel : '0;
  end

  always_comb begin
    rd_ptr_d   = rd_any ? rd_gnt_conv : rd_ptr_q;
    wr_ptr_d   = wr_any ? wr_gnt_conv : wr_ptr_q;
    rd_valid_d = rd_any;
    rd_owner_d = rd_gnt_pool;
    rd_oob_d   = rd_any && !rd_ok;
    // BRAM is read-first, so a same-cycle write to the read address must be bypassed.
    fwd_hit_d  = rd_ok && wr_ok && (rd_addr == wr_addr);
    fwd_data_d = fwd_hit_d ? wr_data_sel : '0;
    oob_err_d  = oob_err_q || (rd_any && !rd_ok) || (wr_any && !wr_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      oob_err_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      rd_oob_q   <= rd_oob_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      oob_err_q  <= oob_err_d;
    end
  end

  always_comb begin
    ret_data          = rd_oob_q ? '0 : (fwd_hit_q ? fwd_data_q : mem_rd_data);
    arb.conv_rd_gnt   = rd_gnt_conv;
    arb.pool_rd_gnt   = rd_gnt_pool;
    arb.conv_wr_gnt   = wr_gnt_conv;
    arb.pool_wr_gnt   = wr_gnt_pool;
    arb.conv_rd_valid = rd_valid_q && !rd_owner_q;
    arb.pool_rd_valid = rd_valid_q &&  rd_owner_q;
    arb.conv_rd_data  = (rd_valid_q && !rd_owner_q) ? ret_data : '0;
    arb.pool_rd_data  = (rd_valid_q &&  rd_owner_q) ? ret_data : '0;
    oob_err           = oob_err_q;
  end
endmodule

// File: tb/tb_fmap_arbiter.sv
// Bench for fmap_arbiter: behavioural BRAM plus a shadow-memory reference model,
// directed scenarios followed by randomized client traffic.
module tb_fmap_arbiter;
  localparam int FW = 32, FH = 32, DW = 32, AW = 10, DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          oob_err;

  fmap_arbiter_if bus ();

  fmap_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .arb        (bus),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .oob_err    (oob_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] h;
    h = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    return (i == 67) ? 32'h1122_3344 : h;
  endfunction

  // Read-first BRAM with one cycle of read latency.
  logic [DW-1:0] bram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) bram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_rd_en) mem_rd_data <= bram[mem_rd_addr];
      if (mem_wr_en) bram[mem_wr_addr] <= mem_wr_data;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  bit          rd_turn_pool, wr_turn_pool;
  bit          exp_vc, exp_vp, oob_exp;
  logic [31:0] exp_d;
  bit          last_gcr, last_gpr, last_gcw, last_gpw;

  function automatic bit inr(input int x, input int y);
    return (x < FW) && (y < FH);
  endfunction

  task automatic model_reset();
    rd_turn_pool = 0; wr_turn_pool = 0;
    exp_vc = 0; exp_vp = 0; exp_d = '0; oob_exp = 0;
  endtask

  task automatic set_rd(input bit pool, input bit req, input int x, input int y);
    if (pool) begin bus.pool_rd_req = req; bus.pool_rd_x = 8'(x); bus.pool_rd_y = 8'(y); end
    else      begin bus.conv_rd_req = req; bus.conv_rd_x = 8'(x); bus.conv_rd_y = 8'(y); end
  endtask

  task automatic set_wr(input bit pool, input bit req, input int x, input int y, input logic [31:0] d);
    if (pool) begin bus.pool_wr_req = req; bus.pool_wr_x = 8'(x); bus.pool_wr_y = 8'(y); bus.pool_wr_data = d; end
    else      begin bus.conv_wr_req = req; bus.conv_wr_x = 8'(x); bus.conv_wr_y = 8'(y); bus.conv_wr_data = d; end
  endtask

  task automatic idle();
    set_rd(0, 0, 0, 0); set_rd(1, 0, 0, 0);
    set_wr(0, 0, 0, 0, '0); set_wr(1, 0, 0, 0, '0);
  endtask

  // One clock of traffic: inputs are already applied; checks happen at the falling edge.
  task automatic cycle();
    bit gcr, gpr, gcw, gpw, oob_next, nvc, nvp;
    int x, y, a;
    logic [31:0] d, nd;
    @(negedge clk);
    chk("conv_rd_valid", 32'(bus.conv_rd_valid), 32'(exp_vc));
    chk("pool_rd_valid", 32'(bus.pool_rd_valid), 32'(exp_vp));
    chk("conv_rd_data", bus.conv_rd_data, exp_vc ? exp_d : 32'h0);
    chk("pool_rd_data", bus.pool_rd_data, exp_vp ? exp_d : 32'h0);
    chk("oob_err", 32'(oob_err), 32'(oob_exp));

    if (bus.conv_rd_req && bus.pool_rd_req) begin gcr = !rd_turn_pool; gpr = rd_turn_pool; end
    else begin gcr = bus.conv_rd_req; gpr = bus.pool_rd_req; end
    if (gcr || gpr) rd_turn_pool = gcr;
    if (bus.conv_wr_req && bus.pool_wr_req) begin gcw = !wr_turn_pool; gpw = wr_turn_pool; end
    else begin gcw = bus.conv_wr_req; gpw = bus.pool_wr_req; end
    if (gcw || gpw) wr_turn_pool = gcw;
    chk("conv_rd_gnt", 32'(bus.conv_rd_gnt), 32'(gcr));
    chk("pool_rd_gnt", 32'(bus.pool_rd_gnt), 32'(gpr));
    chk("conv_wr_gnt", 32'(bus.conv_wr_gnt), 32'(gcw));
    chk("pool_wr_gnt", 32'(bus.pool_wr_gnt), 32'(gpw));

    oob_next = 0;
    if (gcw || gpw) begin
      x = gpw ? int'(bus.pool_wr_x) : int'(bus.conv_wr_x);
      y = gpw ? int'(bus.pool_wr_y) : int'(bus.conv_wr_y);
      d = gpw ? bus.pool_wr_data : bus.conv_wr_data;
      if (inr(x, y)) begin
        a = y * FW + x;
        chk("mem_wr_en", 32'(mem_wr_en), 32'h1);
        chk("mem_wr_addr", 32'(mem_wr_addr), 32'(a));
        chk("mem_wr_data", mem_wr_data, d);
        ref_mem[a] = d;
      end else begin
        chk("mem_wr_en_oob", 32'(mem_wr_en), 32'h0);
        oob_next = 1;
      end
    end else begin
      chk("mem_wr_en_idle", 32'(mem_wr_en), 32'h0);
    end

    nd = '0;
    if (gcr || gpr) begin
      x = gpr ? int'(bus.pool_rd_x) : int'(bus.conv_rd_x);
      y = gpr ? int'(bus.pool_rd_y) : int'(bus.conv_rd_y);
      if (inr(x, y)) begin
        a = y * FW + x;
        chk("mem_rd_en", 32'(mem_rd_en), 32'h1);
        chk("mem_rd_addr", 32'(mem_rd_addr), 32'(a));
        nd = ref_mem[a];
      end else begin
        oob_next = 1;
      end
    end else begin
      chk("mem_rd_en_idle", 32'(mem_rd_en), 32'h0);
    end
    nvc = gcr; nvp = gpr;
    last_gcr = gcr; last_gpr = gpr; last_gcw = gcw; last_gpw = gpw;

    @(posedge clk);
    #1;
    exp_vc = nvc; exp_vp = nvp; exp_d = nd;
    oob_exp = oob_exp || oob_next;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.conv_rd_req = 1'b1;
    bus.pool_wr_req = 1'b1;
    #1;
    chk("rst_conv_rd_gnt", 32'(bus.conv_rd_gnt), 32'h0);
    chk("rst_pool_wr_gnt", 32'(bus.pool_wr_gnt), 32'h0);
    chk("rst_conv_rd_valid", 32'(bus.conv_rd_valid), 32'h0);
    chk("rst_oob_err", 32'(oob_err), 32'h0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic int rcoord();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(32, 40));
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    idle();
    model_reset();
    do_reset();

    // Single conv read of (3,2) -> address 67
    set_rd(0, 1, 3, 2); cycle();
    idle(); cycle();

    // Read-path contention straight out of reset
    do_reset();
    set_rd(0, 1, 1, 0); set_rd(1, 1, 2, 0);
    repeat (4) cycle();
    idle(); cycle();

    // Write-path contention straight out of reset
    do_reset();
    set_wr(0, 1, 4, 3, 32'hA5A5_0001); set_wr(1, 1, 6, 3, 32'h5A5A_0002);
    repeat (4) cycle();
    idle(); cycle();

    // Same-address write and read in one cycle, then different addresses
    set_wr(0, 1, 5, 1, 32'hDEAD_BEEF); set_rd(1, 1, 5, 1); cycle();
    set_wr(0, 1, 7, 1, 32'hCAFE_F00D); set_rd(1, 1, 9, 2); cycle();
    idle(); cycle();
    set_rd(0, 1, 5, 1); cycle();
    idle(); cycle();

    // Out-of-range write and read; the error flag is sticky
    set_wr(1, 1, 32, 0, 32'h1234_5678); cycle();
    idle(); set_rd(0, 1, 0, 40); cycle();
    idle(); repeat (3) cycle();

    // Reset lands on the cycle after a read grant
    set_rd(0, 1, 10, 10); cycle();
    idle();
    rst = 1'b1;
    #1;
    chk("midrst_conv_rd_valid", 32'(bus.conv_rd_valid), 32'h0);
    chk("midrst_conv_rd_data", bus.conv_rd_data, 32'h0);
    chk("midrst_oob_err", 32'(oob_err), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_rd(0, 1, 1, 1); set_rd(1, 1, 2, 2); cycle();
    idle(); cycle();

    // Full-map back-to-back stream from conv
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(0, 1, i % FW, i / FW);
      cycle();
    end
    idle(); cycle();

    // Randomized traffic: each client holds its request until granted
    idle();
    last_gcr = 0; last_gpr = 0; last_gcw = 0; last_gpw = 0;
    for (int n = 0; n < 400; n++) begin
      if (!bus.conv_rd_req || last_gcr) set_rd(0, $urandom_range(0, 3) != 0, rcoord(), rcoord());
      if (!bus.pool_rd_req || last_gpr) set_rd(1, $urandom_range(0, 3) != 0, rcoord(), rcoord());
      if (!bus.conv_wr_req || last_gcw) set_wr(0, $urandom_range(0, 2) != 0, rcoord(), rcoord(), $urandom);
      if (!bus.pool_wr_req || last_gpw) set_wr(1, $urandom_range(0, 2) != 0, rcoord(), rcoord(), $urandom);
      cycle();
    end
    idle(); cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
